moving_avg_scheduler: RTL

Sequences a moving-average difference filter stage (running-sum input, variable delay line, registered difference output). The block generates the filter's sample-rate clock enable from a programmable prescaler, and applies DELAY changes through a ready/valid config handshake. On every enable or DELAY change it resets and refills the delay line, and emits OUT_STROBE only when the filter output is valid. It sits between the sensor control registers and the filter instance.

---
 rtl/moving_avg_scheduler.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/moving_avg_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : moving_avg_scheduler
// Description : Sequences a moving-average difference filter stage. It
//               generates the filter sample-rate clock enable from a
//               programmable prescaler, applies DELAY changes through a
//               ready/valid handshake, resets and refills the delay line on
//               every enable or DELAY change, and flags valid filter outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module moving_avg_scheduler #(
   parameter int DELAY_BITS = 4,
   parameter int DIV_BITS   = 16
) (
   input  logic                  CLK,
   input  logic                  RESET_N,
   input  logic                  ENABLE,
   input  logic [DIV_BITS-1:0]   DIVIDER,
   input  logic                  CFG_VALID,
   input  logic [DELAY_BITS-1:0] CFG_DELAY,
   output logic                  CFG_READY,
   output logic                  FILTER_CE,
   output logic                  FILTER_RESET,
   output logic [DELAY_BITS-1:0] FILTER_DELAY,
   output logic                  OUT_STROBE,
   output logic                  FILL_ACTIVE
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FILL = 2'd1,
      S_RUN  = 2'd2
   } state_t;

   localparam logic [DIV_BITS-1:0]   c_cnt_one  = {{(DIV_BITS-1){1'b0}}, 1'b1};
   localparam logic [DELAY_BITS:0]   c_fill_one = {{DELAY_BITS{1'b0}}, 1'b1};

   state_t                r_state;
   logic [DIV_BITS-1:0]   r_cnt;
   logic [DIV_BITS-1:0]   r_div;
   logic [DELAY_BITS:0]   r_fill;
   logic [DELAY_BITS-1:0] r_delay;
   logic                  r_ce;
   logic                  r_frst;
   logic                  r_strobe;
   logic                  r_fill_act;
   logic                  r_ready;

   state_t                w_state_nxt;
   logic [DIV_BITS-1:0]   w_cnt_nxt;
   logic [DIV_BITS-1:0]   w_div_nxt;
   logic [DELAY_BITS:0]   w_fill_nxt;
   logic [DELAY_BITS:0]   w_fill_target;
   logic [DELAY_BITS-1:0] w_delay_nxt;
   logic                  w_accept;
   logic                  w_pulse;
   logic                  w_ce_nxt;
   logic                  w_frst_nxt;
   logic                  w_strobe_nxt;
   logic                  w_fill_act_nxt;
   logic                  w_ready_nxt;

   // The fill completes on the (DELAY+2)-th CE, i.e. when DELAY+1 CEs were
   // already counted; one extra counter bit keeps DELAY=max from wrapping.
   assign w_fill_target = {1'b0, r_delay} + c_fill_one;
   // READY is only high in IDLE and RUN, so this is the complete accept term.
   assign w_accept      = CFG_VALID & r_ready;

   // Next-state, prescaler, fill counter and next registered output values.
   always_comb begin
      w_state_nxt = r_state;
      w_delay_nxt = r_delay;
      w_pulse     = 1'b0;

      if (w_accept) begin
         w_delay_nxt = CFG_DELAY;
      end

      case (r_state)
         S_IDLE: begin
            if (ENABLE) begin
               w_state_nxt = S_FILL;
            end
         end
         S_FILL: begin
            if (!ENABLE) begin
               w_state_nxt = S_IDLE;
            end else if (r_ce && (r_fill == w_fill_target)) begin
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (!ENABLE) begin
               w_state_nxt = S_IDLE;
            end else if (w_accept) begin
               // New delay in RUN: one-cycle filter reset, then refill.
               w_state_nxt = S_FILL;
               w_pulse     = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      w_frst_nxt = (w_state_nxt == S_IDLE) | w_pulse;

      // Prescaler restarts at 0 while the filter is (or is about to be) held
      // in reset, and after every CE; DIVIDER is re-sampled at each restart.
      if (w_frst_nxt || r_frst || r_ce) begin
         w_cnt_nxt = '0;
         w_div_nxt = DIVIDER;
      end else begin
         w_cnt_nxt = r_cnt + c_cnt_one;
         w_div_nxt = r_div;
      end

      if (w_frst_nxt || r_frst) begin
         w_fill_nxt = '0;
      end else if ((r_state == S_FILL) && r_ce) begin
         w_fill_nxt = r_fill + c_fill_one;
      end else begin
         w_fill_nxt = r_fill;
      end

      w_ce_nxt       = (w_state_nxt != S_IDLE) & ~w_frst_nxt & (w_cnt_nxt == w_div_nxt);
      // A CE yields a valid output next cycle only if the state stays/lands in
      // RUN; leaving RUN (disable or reconfig) suppresses it.
      w_strobe_nxt   = r_ce & (w_state_nxt == S_RUN);
      w_fill_act_nxt = (w_state_nxt == S_FILL);
      w_ready_nxt    = (w_state_nxt != S_FILL);
   end

   // State, counters and all registered outputs.
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_div      <= '0;
         r_fill     <= '0;
         r_delay    <= '0;
         r_ce       <= 1'b0;
         r_frst     <= 1'b1;
         r_strobe   <= 1'b0;
         r_fill_act <= 1'b0;
         r_ready    <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_div      <= w_div_nxt;
         r_fill     <= w_fill_nxt;
         r_delay    <= w_delay_nxt;
         r_ce       <= w_ce_nxt;
         r_frst     <= w_frst_nxt;
         r_strobe   <= w_strobe_nxt;
         r_fill_act <= w_fill_act_nxt;
         r_ready    <= w_ready_nxt;
      end
   end

   assign CFG_READY    = r_ready;
   assign FILTER_CE    = r_ce;
   assign FILTER_RESET = r_frst;
   assign FILTER_DELAY = r_delay;
   assign OUT_STROBE   = r_strobe;
   assign FILL_ACTIVE  = r_fill_act;

endmodule
`default_nettype wire
